pipe_run_ctl: RTL and testbench
===============================

// Module: pipe_run_ctl
// PURPOSE
//  Run/step/breakpoint sequencer for the 5-stage pipeline. Drives the datapath global clock enable.
//  Inputs: debounced front-panel buttons, a fetch-PC breakpoint comparator and a core halt request.
//  Sits between the board buttons and the pipeline top, replacing the bare button toggle flop.
// PARAMETERS
//  DEBOUNCE_CYCLES  16'd50000  cycles a synchronized button level must stay stable before it is accepted
//  STEP_W           16         width of step counter / i_step_count
//  PC_W             32         width of PC and breakpoint address
// PORTS
//  i_clk          in   1       system clock, all logic on rising edge
//  i_rst          in   1       asynchronous, active-low reset
//  i_btn_run      in   1       raw run/halt toggle button, asynchronous
//  i_btn_step     in   1       raw step button, asynchronous
//  i_step_count   in   STEP_W  instructions per step burst; 0 is treated as 1
//  i_bp_en        in   1       breakpoint enable
//  i_bp_addr      in   PC_W    breakpoint address, compared against fetch PC
//  i_pc_f         in   PC_W    current fetch-stage PC from datapath
//  i_halt_req     in   1       core halt request (e.g. ecall), level
//  o_clk_en       out  1       pipeline clock enable
//  o_state        out  2       00 HALT, 01 RUN, 10 STEP, 11 BRK
//  o_bp_hit       out  1       high while in BRK
//  o_steps_left   out  STEP_W  remaining cycles of current step burst
// BEHAVIOUR
//  Reset (i_rst=0, async): state=HALT; o_clk_en=0, o_bp_hit=0, o_steps_left=0, bp_mask=0, debounce state cleared.
//  Buttons: 2-FF synchronizer, then counter. Accepted level changes after DEBOUNCE_CYCLES stable cycles.
//    Each accepted 0->1 press produces a 1-cycle pulse (run_p / step_p). Release makes no pulse.
//    Latency from a stable raw press to the pulse is 2 + DEBOUNCE_CYCLES cycles.
//  bp_fire = i_bp_en & (i_pc_f == i_bp_addr) & ~bp_mask (combinational).
//  o_clk_en = (state==RUN & ~bp_fire) | (state==STEP). It is combinational from registered state, so the
//    instruction at i_bp_addr is never advanced past fetch.
//  Priority per cycle: reset > run_p > bp_fire > i_halt_req > step_p.
//  HALT: run_p -> RUN. step_p -> STEP, o_steps_left <= max(i_step_count,1).
//  RUN:  run_p -> HALT. bp_fire -> BRK. i_halt_req -> HALT. step_p is ignored.
//  STEP: o_steps_left decrements each cycle. When it is 1 -> HALT, and it reaches 0 on that edge.
//    run_p aborts to HALT and clears o_steps_left. bp_fire is ignored in STEP; the user steps through the BP.
//    step_p and i_halt_req are ignored.
//  BRK:  o_clk_en=0, o_bp_hit=1. run_p -> RUN with bp_mask<=1. step_p -> STEP (load as in HALT).
//  bp_mask clears after the first cycle with o_clk_en=1, so resuming does not re-trap on the same PC.
//    It also clears in HALT.
//  o_steps_left does not wrap: it is loaded only from HALT/BRK and saturates at 0.
//  Changing i_bp_addr or i_bp_en takes effect the same cycle. There is no pending state.
//  Reset asserted mid-burst or mid-debounce abandons everything. The next press needs a full debounce.
// CONFIGURATION
//  PIPE_RUN_CYCLE_CNT_EN defined: adds output o_cycle_cnt [31:0].
//    It counts cycles with o_clk_en=1, wraps at 2^32 and resets to 0.
//  PIPE_RUN_CYCLE_CNT_EN undefined: the port and counter are absent; all other behaviour is identical.
// TESTING (bench uses DEBOUNCE_CYCLES=4, STEP_W=8, PC_W=32)
//  1. Reset release, no buttons.
//     -> state=HALT and o_clk_en=0 for 100 cycles.
//  2. i_btn_run held high 10 cycles.
//     -> exactly one run_p 6 cycles after the press, then o_state=01 and o_clk_en=1.
//     -> a 3-cycle glitch produces no transition.
//  3. HALT, i_step_count=3, step press.
//     -> o_clk_en=1 for exactly 3 cycles, o_steps_left 3,2,1,0, then HALT.
//     -> with i_step_count=0, exactly 1 cycle.
//  4. RUN, i_bp_en=1, i_bp_addr=0x40, i_pc_f reaches 0x40.
//     -> o_clk_en=0 that same cycle, next cycle o_state=11 and o_bp_hit=1.
//     -> run press resumes and does not re-trap while i_pc_f stays 0x40 for one enabled cycle.
//  5. RUN, i_halt_req and bp_fire in the same cycle.
//     -> BRK. Run and step pulses forced in the same cycle from HALT -> RUN.
//  6. Reset low mid step burst (o_steps_left=5).
//     -> outputs zero immediately (async), state HALT.
//     -> with PIPE_RUN_CYCLE_CNT_EN, o_cycle_cnt=0.

Source files
------------

// File: rtl/pipe_run_ctl_if.sv
// Front-panel and datapath signal bundle for the run/step/breakpoint sequencer.
// Carries o_cycle_cnt only when PIPE_RUN_CYCLE_CNT_EN is defined.
interface pipe_run_ctl_if #(
    parameter int STEP_W = 16,
    parameter int PC_W   = 32
);
    logic              i_btn_run;
    logic              i_btn_step;
    logic [STEP_W-1:0] i_step_count;
    logic              i_bp_en;
    logic [PC_W-1:0]   i_bp_addr;
    logic [PC_W-1:0]   i_pc_f;
    logic              i_halt_req;
    logic              o_clk_en;
    logic [1:0]        o_state;
    logic              o_bp_hit;
    logic [STEP_W-1:0] o_steps_left;
`ifdef PIPE_RUN_CYCLE_CNT_EN
    logic [31:0]       o_cycle_cnt;
`endif

    modport master (
        output i_btn_run, i_btn_step, i_step_count,
        output i_bp_en, i_bp_addr, i_pc_f, i_halt_req,
`ifdef PIPE_RUN_CYCLE_CNT_EN
        input  o_cycle_cnt,
`endif
        input  o_clk_en, o_state, o_bp_hit, o_steps_left
    );

    modport slave (
        input  i_btn_run, i_btn_step, i_step_count,
        input  i_bp_en, i_bp_addr, i_pc_f, i_halt_req,
`ifdef PIPE_RUN_CYCLE_CNT_EN
        output o_cycle_cnt,
`endif
        output o_clk_en, o_state, o_bp_hit, o_steps_left
    );
endinterface

// File: rtl/pipe_run_ctl.sv
// Run/step/breakpoint sequencer driving the pipeline clock enable.
// Optional enabled-cycle counter: define PIPE_RUN_CYCLE_CNT_EN.
module pipe_run_ctl #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          STEP_W          = 16,
    parameter int          PC_W            = 32
) (
    input logic           i_clk,
    input logic           i_rst,
    pipe_run_ctl_if.slave bus
);
    localparam logic [1:0] S_HALT = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_STEP = 2'b10;
    localparam logic [1:0] S_BRK  = 2'b11;

    logic [1:0]  w_raw;
    logic [1:0]  r_s1;
    logic [1:0]  r_s2;
    logic [1:0]  r_lvl;
    logic [1:0]  r_pulse;
    logic [15:0] r_cnt [2];

    assign w_raw = {bus.i_btn_step, bus.i_btn_run};

    // Bit 0 is run, bit 1 is step; a level is accepted only after a full stable window.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_lvl    <= '0;
            r_pulse  <= '0;
            r_cnt[0] <= '0;
            r_cnt[1] <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
            for (int b = 0; b < 2; b++) begin
                r_pulse[b] <= 1'b0;
                if (r_s2[b] == r_lvl[b]) begin
                    r_cnt[b] <= '0;
                end else if ({1'b0, r_cnt[b]} + 17'd1 >= {1'b0, DEBOUNCE_CYCLES}) begin
                    r_cnt[b]   <= '0;
                    r_lvl[b]   <= r_s2[b];
                    r_pulse[b] <= r_s2[b];
                end else begin
                    r_cnt[b] <= r_cnt[b] + 16'd1;
                end
            end
        end
    end

    logic              r_bp_mask;
    logic [1:0]        r_state;
    logic [STEP_W-1:0] r_steps;
    logic              w_run_p;
    logic              w_step_p;
    logic [PC_W-1:0]   w_pc_diff;
    logic              w_bp_fire;
    logic              w_clk_en;
    logic [STEP_W-1:0] w_load;

    assign w_run_p   = r_pulse[0];
    assign w_step_p  = r_pulse[1];
    assign w_pc_diff = bus.i_pc_f ^ bus.i_bp_addr;
    assign w_bp_fire = bus.i_bp_en & ~(|w_pc_diff) & ~r_bp_mask;
    // Gated the same cycle the PC matches, so the BP instruction stays in fetch.
    assign w_clk_en  = ((r_state == S_RUN) & ~w_bp_fire) | (r_state == S_STEP);
    assign w_load    = (bus.i_step_count == '0) ? STEP_W'(1) : bus.i_step_count;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state   <= S_HALT;
            r_steps   <= '0;
            r_bp_mask <= 1'b0;
        end else begin
            unique case (r_state)
                S_HALT: begin
                    if (w_run_p) begin
                        r_state <= S_RUN;
                    end else if (w_step_p) begin
                        r_state <= S_STEP;
                        r_steps <= w_load;
                    end
                end
                S_RUN: begin
                    if (w_run_p)              r_state <= S_HALT;
                    else if (w_bp_fire)       r_state <= S_BRK;
                    else if (bus.i_halt_req)  r_state <= S_HALT;
                end
                S_STEP: begin
                    if (w_run_p || r_steps <= STEP_W'(1)) begin
                        r_state <= S_HALT;
                        r_steps <= '0;
                    end else begin
                        r_steps <= r_steps - STEP_W'(1);
                    end
                end
                S_BRK: begin
                    if (w_run_p) begin
                        r_state <= S_RUN;
                    end else if (w_step_p) begin
                        r_state <= S_STEP;
                        r_steps <= w_load;
                    end
                end
                default: r_state <= S_HALT;
            endcase

            // Mask lets a resume from BRK advance past the trapping PC once.
            if ((r_state == S_BRK) && w_run_p)
                r_bp_mask <= 1'b1;
            else if (w_clk_en || (r_state == S_HALT))
                r_bp_mask <= 1'b0;
        end
    end

    assign bus.o_clk_en     = w_clk_en;
    assign bus.o_state      = r_state;
    assign bus.o_bp_hit     = (r_state == S_BRK);
    assign bus.o_steps_left = r_steps;

`ifdef PIPE_RUN_CYCLE_CNT_EN
    logic [31:0] r_cyc;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)        r_cyc <= '0;
        else if (w_clk_en) r_cyc <= r_cyc + 32'd1;
    end

    assign bus.o_cycle_cnt = r_cyc;
`endif
endmodule

// File: tb/tb_pipe_run_ctl.sv
// Bench for pipe_run_ctl: directed scenarios plus random button/PC traffic
// checked every cycle against a behavioural model.
module tb_pipe_run_ctl;
    localparam int DEB  = 4;
    localparam int HALT = 0;
    localparam int RUN  = 1;
    localparam int STEP = 2;
    localparam int BRK  = 3;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   en_cnt;

    pipe_run_ctl_if #(.STEP_W(8), .PC_W(32)) bus ();

    pipe_run_ctl #(
        .DEBOUNCE_CYCLES(16'd4),
        .STEP_W(8),
        .PC_W(32)
    ) u_dut (
        .i_clk(clk),
        .i_rst(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int        m_st;
    int        m_steps;
    bit        m_mask;
    bit        m_lr;
    bit        m_ls;
    bit        m_pr;
    bit        m_ps;
    bit [31:0] m_cyc;
    bit        hr[$];
    bit        hs[$];

    task automatic chk(input string tag, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic bit win_differs(input bit q[$], input bit lvl);
        for (int i = 0; i < DEB; i++)
            if (q[q.size() - 2 - i] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void m_reset();
        m_st = HALT; m_steps = 0; m_mask = 0;
        m_lr = 0; m_ls = 0; m_pr = 0; m_ps = 0; m_cyc = '0;
        hr.delete(); hs.delete();
        for (int i = 0; i < DEB + 2; i++) begin
            hr.push_back(1'b0);
            hs.push_back(1'b0);
        end
    endfunction

    // Called at negedge with inputs settled; ends at the next negedge.
    task automatic cyc();
        bit fire, en, npr, nps, nmask;
        int nst, nsteps, ld;
        #1;
        fire = bus.i_bp_en && (bus.i_pc_f == bus.i_bp_addr) && !m_mask;
        en   = (m_st == RUN && !fire) || m_st == STEP;
        chk("state", bus.o_state, m_st);
        chk("clk_en", bus.o_clk_en, en);
        chk("bp_hit", bus.o_bp_hit, m_st == BRK);
        chk("steps", bus.o_steps_left, m_steps);
`ifdef PIPE_RUN_CYCLE_CNT_EN
        chk("cyc_cnt", bus.o_cycle_cnt, m_cyc);
`endif
        en_cnt += int'(bus.o_clk_en);
        ld = (bus.i_step_count == 0) ? 1 : int'(bus.i_step_count);
        nst = m_st; nsteps = m_steps; nmask = m_mask;
        case (m_st)
            HALT: if (m_pr) nst = RUN;
                  else if (m_ps) begin nst = STEP; nsteps = ld; end
            RUN:  if (m_pr || (!fire && bus.i_halt_req)) nst = HALT;
                  else if (fire) nst = BRK;
            STEP: begin
                nsteps = (m_steps > 0) ? m_steps - 1 : 0;
                if (m_pr) nsteps = 0;
                if (nsteps == 0) nst = HALT;
            end
            default: if (m_pr) nst = RUN;
                     else if (m_ps) begin nst = STEP; nsteps = ld; end
        endcase
        if (m_st == BRK && m_pr) nmask = 1;
        else if (en || m_st == HALT) nmask = 0;
        npr = 0; nps = 0;
        @(posedge clk);
        if (win_differs(hr, m_lr)) begin m_lr = !m_lr; npr = m_lr; end
        if (win_differs(hs, m_ls)) begin m_ls = !m_ls; nps = m_ls; end
        hr.push_back(bus.i_btn_run);
        hs.push_back(bus.i_btn_step);
        if (hr.size() > DEB + 4) begin
            void'(hr.pop_front());
            void'(hs.pop_front());
        end
        m_st = nst; m_steps = nsteps; m_mask = nmask;
        m_pr = npr; m_ps = nps; m_cyc += 32'(en);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_state", bus.o_state, 0);
        chk("rst_clk_en", bus.o_clk_en, 0);
        chk("rst_bp_hit", bus.o_bp_hit, 0);
        chk("rst_steps", bus.o_steps_left, 0);
`ifdef PIPE_RUN_CYCLE_CNT_EN
        chk("rst_cyc_cnt", bus.o_cycle_cnt, 0);
`endif
        m_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic press(input bit run, input bit step, input int hold, input int gap);
        bus.i_btn_run  = run;
        bus.i_btn_step = step;
        repeat (hold) cyc();
        bus.i_btn_run  = 1'b0;
        bus.i_btn_step = 1'b0;
        repeat (gap) cyc();
    endtask

    initial begin
        int first;
        n_cmp = 0; n_bad = 0; en_cnt = 0;
        rst_n = 1'b0;
        bus.i_btn_run = 0; bus.i_btn_step = 0; bus.i_step_count = 8'd1;
        bus.i_bp_en = 0; bus.i_bp_addr = 32'h0; bus.i_pc_f = 32'h10;
        bus.i_halt_req = 0;
        m_reset();
        @(negedge clk);
        do_reset();

        repeat (100) cyc();

        // Run press: state flips after 2 sync + DEB debounce + 1 FSM edge.
        bus.i_btn_run = 1'b1;
        first = -1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (first < 0 && bus.o_state == 2'b01) first = i + 1;
        end
        chk("run_latency", first, 7);
        bus.i_btn_run = 1'b0;
        repeat (8) cyc();
        press(1, 0, 3, 10);
        chk("glitch_ignored", bus.o_state, RUN);
        press(1, 0, 10, 8);
        chk("run_to_halt", bus.o_state, HALT);

        bus.i_step_count = 8'd3;
        en_cnt = 0;
        press(0, 1, 10, 12);
        chk("step3_cycles", en_cnt, 3);
        bus.i_step_count = 8'd0;
        en_cnt = 0;
        press(0, 1, 10, 12);
        chk("step0_cycles", en_cnt, 1);

        bus.i_bp_en = 1; bus.i_bp_addr = 32'h40; bus.i_pc_f = 32'h10;
        press(1, 0, 10, 8);
        bus.i_pc_f = 32'h40;
        #1;
        chk("bp_gate", bus.o_clk_en, 0);
        cyc();
        chk("bp_state", bus.o_state, BRK);
        chk("bp_hit", bus.o_bp_hit, 1);
        bus.i_btn_run = 1'b1;
        for (int i = 0; i < 12 && m_st != RUN; i++) cyc();
        chk("resume_reached", bus.o_state, RUN);
        #1;
        chk("resume_en", bus.o_clk_en, 1);
        cyc();
        bus.i_pc_f = 32'h44;
        repeat (3) cyc();
        bus.i_btn_run = 1'b0;
        repeat (8) cyc();
        chk("no_retrap", bus.o_state, RUN);

        bus.i_bp_addr = 32'h80; bus.i_pc_f = 32'h80; bus.i_halt_req = 1;
        cyc();
        chk("bp_over_halt", bus.o_state, BRK);
        bus.i_halt_req = 0; bus.i_bp_en = 0;
        do_reset();
        press(1, 1, 10, 8);
        chk("run_over_step", bus.o_state, RUN);

        do_reset();
        bus.i_step_count = 8'd8;
        bus.i_btn_step = 1'b1;
        for (int i = 0; i < 20 && !(m_st == STEP && m_steps == 5); i++) cyc();
        chk("burst_at5", bus.o_steps_left, 5);
        do_reset();
        bus.i_btn_step = 1'b0;
        repeat (10) cyc();

        for (int s = 0; s < 250; s++) begin
            int n;
            bus.i_step_count = 8'($urandom_range(0, 6));
            bus.i_bp_en      = 1'($urandom_range(0, 1));
            bus.i_bp_addr    = 32'h100;
            bus.i_halt_req   = ($urandom_range(0, 7) == 0);
            bus.i_btn_run    = ($urandom_range(0, 3) == 0);
            bus.i_btn_step   = ($urandom_range(0, 2) == 0);
            n = int'($urandom_range(1, 9));
            for (int c = 0; c < n; c++) begin
                if ($urandom_range(0, 3) == 0) bus.i_pc_f = 32'h100;
                else bus.i_pc_f = 32'h100 + 32'(4 * $urandom_range(1, 3));
                cyc();
            end
            if ($urandom_range(0, 59) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
